pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Instruction-fetch front end sitting directly upstream of the PC register stage.
//  - Owns the program counter; issues one-at-a-time requests to instruction memory.
//  - Buffers returned {pc, instr} pairs in a small queue for decode.
//  - Handles branch/jump redirects, squashing stale in-flight responses.
// PARAMETERS
//  AW        32            address/PC width (bits)
//  IW        32            instruction width (bits)
//  RESET_PC  32'h0000_0000 PC value loaded on reset
//  DEPTH     2             fetch-queue entries (power of 2, >=2)
// PORTS
//  clk             in   1   clock, all state updates on posedge
//  rst             in   1   reset, asynchronous, active-low
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_addr       out  AW  fetch address (= current PC)
//  imem_rsp_valid  in   1   response data valid (1 pulse per accepted request)
//  imem_rsp_data   in   IW  fetched instruction
//  redirect_valid  in   1   branch/jump taken: restart fetch at redirect_pc
//  redirect_pc     in   AW  new PC target (word aligned)
//  if_valid        out  1   queue head valid to decode
//  if_ready        in   1   decode consumes head this cycle
//  if_pc           out  AW  PC of head entry
//  if_instr        out  IW  instruction of head entry
// BEHAVIOUR
//  - Reset (rst=0, async): pc=RESET_PC, state=IDLE, queue empty, all outputs 0
//    except imem_addr=RESET_PC. A request aborted mid-flight by reset is forgotten.
//  - FSM states: IDLE, REQ, WAIT, DROP.
//    IDLE -> REQ  when queue free slots > 0 (free = DEPTH - count).
//    REQ: imem_req_valid=1, imem_addr=pc; on req_ready -> WAIT, latch req_pc=pc, pc<=pc+4.
//    WAIT: on rsp_valid push {req_pc, rsp_data}; -> REQ if space after push, else IDLE.
//    DROP: in-flight response is stale; on rsp_valid discard it -> REQ (or IDLE if full).
//  - At most one outstanding request. Never request with no free slot (the slot
//    is reserved at acceptance, so a push never overflows).
//  - PC arithmetic: pc+4 modulo 2^AW (wraps at all-ones to 0, no flag).
//  - Redirect (highest priority, any state):
//    pc<=redirect_pc; queue flushed (count=0, if_valid=0 next cycle);
//    if WAIT or (REQ with req_ready same cycle) -> DROP; otherwise -> REQ.
//    Redirect + rsp_valid same cycle in WAIT: response discarded, -> REQ.
//    Redirect in DROP: stay DROP, pc updated.
//  - Queue: FIFO, push and pop in same cycle allowed (count unchanged);
//    pop when if_valid & if_ready; if_pc/if_instr from head register (no comb
//    path from imem_rsp_data to if_instr). Latency: rsp_valid at cycle N ->
//    if_valid at N+1 when queue was empty.
//  - imem_req_valid, once asserted, holds with stable imem_addr until req_ready
//    unless a redirect occurs (addr then changes to redirect_pc, valid stays 1).
//  - if_ready while empty: ignored. Pop during redirect: flush wins.
// TESTING
//  1 Reset release, req_ready=1, 1-cycle rsp, if_ready=1 -> addrs 0,4,8,C; if_pc
//    sequence 0,4,8,C with matching instr, one req per 2 cycles.
//  2 if_ready=0 for 10 cycles -> exactly DEPTH=2 entries fetched, then
//    imem_req_valid=0; release -> fetch resumes at 0x8.
//  3 Redirect to 0x100 while in WAIT -> stale rsp dropped (never on if_instr),
//    next imem_addr=0x100, first if_pc=0x100.
//  4 Redirect coincident with rsp_valid -> rsp discarded, queue empty, next req 0x100.
//  5 RESET_PC=32'hFFFF_FFFC -> second fetch addr 0x0000_0000 (wrap).
//  6 Assert rst low mid-WAIT, release -> queue empty, first addr RESET_PC, late
//    rsp from pre-reset request before new req accepted is not pushed.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC owner, single-outstanding imem fetch, redirect squash, fetch queue to decode
module pc_fetch_unit #(
    parameter int             AW       = 32,
    parameter int             IW       = 32,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter int             DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rsp_valid,
    input  logic [IW-1:0] imem_rsp_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [AW-1:0] if_pc,
    output logic [IW-1:0] if_instr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] pc, req_pc;
    logic [AW-1:0] pc_q [DEPTH];
    logic [IW-1:0] instr_q [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_after;
    logic          accept, push, pop;

    assign accept      = state == REQ && imem_req_ready;
    assign push        = state == WAIT && imem_rsp_valid && !redirect_valid;
    assign pop         = if_valid && if_ready;
    assign count_after = count + CW'(push) - CW'(pop);

    // State register; reset abandons any in-flight request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state; a redirect retargets fetch and squashes any response still owed
    always_comb begin
        state_nxt = state;
        if (redirect_valid)
            state_nxt = (accept || ((state == WAIT || state == DROP) && !imem_rsp_valid)) ? DROP : REQ;
        else
            case (state)
                IDLE: state_nxt = (count < FULL) ? REQ : IDLE;
                REQ:  state_nxt = accept ? WAIT : REQ;
                WAIT: state_nxt = imem_rsp_valid ? ((count_after < FULL) ? REQ : IDLE) : WAIT;
                DROP: state_nxt = imem_rsp_valid ? ((count_after < FULL) ? REQ : IDLE) : DROP;
            endcase
    end

    // Outputs; queue head comes straight from registers
    always_comb begin
        imem_req_valid = state == REQ;
        imem_addr      = pc;
        if_valid       = count != '0;
        if_pc          = pc_q[rd_ptr];
        if_instr       = instr_q[rd_ptr];
    end

    // Program counter and the PC of the outstanding request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            if (redirect_valid) pc <= redirect_pc;
            else if (accept)    pc <= pc + AW'(4);
            if (accept) req_pc <= pc;
        end
    end

    // Fetch queue; redirect flush overrides any same-cycle pop or push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_q[wr_ptr]    <= req_pc;
                instr_q[wr_ptr] <= imem_rsp_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_after;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of fetch flow, backpressure, redirects, PC wrap and reset
module tb_pc_fetch_unit;
    logic        clk = 0;
    logic        rst = 0;
    logic        req_ready = 0, rsp_valid = 0, redirect_valid = 0, if_ready = 0;
    logic [31:0] rsp_data = 0, redirect_pc = 0;
    logic        req_valid, if_valid, w_req_valid, w_if_valid;
    logic [31:0] addr, if_pc, if_instr, w_addr, w_if_pc, w_if_instr;
    int          total = 0, bad = 0;
    int          lat = 1, wait_n = 0;
    bit          pend = 0;
    logic [31:0] paddr = 0;

    pc_fetch_unit u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(req_ready), .imem_addr(w_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(w_if_valid), .if_ready(if_ready), .if_pc(w_if_pc), .if_instr(w_if_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fi(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // one clock; memory answers an accepted request after lat cycles
    task automatic tick();
        bit          acc;
        logic [31:0] a;
        acc = req_valid && req_ready;
        a   = addr;
        @(posedge clk); #1;
        rsp_valid = 0;
        if (acc) begin pend = 1; wait_n = lat; paddr = a; end
        if (pend) begin
            if (wait_n <= 1) begin rsp_valid = 1; rsp_data = fi(paddr); pend = 0; end
            else wait_n--;
        end
    endtask

    initial begin
        @(posedge clk); #1;
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        rst = 1;
        chk("idle_req_valid", {31'b0, req_valid}, 32'd0);
        // 1: streaming fetch
        req_ready = 1; if_ready = 1; lat = 1;
        tick();
        chk("t1_req_valid", {31'b0, req_valid}, 32'd1);
        chk("t1_addr0", addr, 32'h0);
        chk("t5_wrap_addr0", w_addr, 32'hFFFF_FFFC);
        tick();
        chk("t1_wait_req", {31'b0, req_valid}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t1_if_valid", {31'b0, if_valid}, 32'd1);
            chk("t1_if_pc", if_pc, 32'(4 * (k - 1)));
            chk("t1_if_instr", if_instr, fi(32'(4 * (k - 1))));
            chk("t1_addr", addr, 32'(4 * k));
            chk("t5_wrap_addr", w_addr, 32'(4 * k - 4));
            tick();
            chk("t1_wait_req", {31'b0, req_valid}, 32'd0);
            chk("t1_popped", {31'b0, if_valid}, 32'd0);
        end
        // 2: decode stall fills exactly DEPTH entries
        rst = 0; pend = 0; rsp_valid = 0; if_ready = 0;
        tick();
        rst = 1;
        repeat (10) tick();
        chk("t2_stall_req", {31'b0, req_valid}, 32'd0);
        chk("t2_head_valid", {31'b0, if_valid}, 32'd1);
        chk("t2_head_pc", if_pc, 32'h0);
        chk("t2_head_instr", if_instr, fi(32'h0));
        if_ready = 1;
        tick();
        chk("t2_second_pc", if_pc, 32'h4);
        chk("t2_still_idle", {31'b0, req_valid}, 32'd0);
        tick();
        chk("t2_drained", {31'b0, if_valid}, 32'd0);
        chk("t2_resume_req", {31'b0, req_valid}, 32'd1);
        chk("t2_resume_addr", addr, 32'h8);
        // 3: redirect in WAIT, stale response dropped
        lat = 3;
        tick();
        redirect_valid = 1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 0;
        chk("t3_drop_req", {31'b0, req_valid}, 32'd0);
        chk("t3_flushed", {31'b0, if_valid}, 32'd0);
        tick();
        chk("t3_drop_wait", {31'b0, req_valid}, 32'd0);
        lat = 1;
        tick();
        chk("t3_stale_not_pushed", {31'b0, if_valid}, 32'd0);
        chk("t3_new_req", {31'b0, req_valid}, 32'd1);
        chk("t3_new_addr", addr, 32'h100);
        tick();
        tick();
        chk("t3_if_valid", {31'b0, if_valid}, 32'd1);
        chk("t3_if_pc", if_pc, 32'h100);
        chk("t3_if_instr", if_instr, fi(32'h100));
        // 4: redirect coincident with response, queue holding an entry
        if_ready = 0;
        tick();
        chk("t4_rsp_pending", {31'b0, rsp_valid}, 32'd1);
        redirect_valid = 1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 0;
        chk("t4_flushed", {31'b0, if_valid}, 32'd0);
        chk("t4_req", {31'b0, req_valid}, 32'd1);
        chk("t4_addr", addr, 32'h100);
        tick();
        tick();
        chk("t4_if_valid", {31'b0, if_valid}, 32'd1);
        chk("t4_if_pc", if_pc, 32'h100);
        chk("t4_if_instr", if_instr, fi(32'h100));
        if_ready = 1;
        // redirect while a request waits for ready: valid holds, addr retargets
        req_ready = 0;
        tick();
        chk("hold_req", {31'b0, req_valid}, 32'd1);
        chk("hold_addr", addr, 32'h104);
        redirect_valid = 1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 0;
        chk("retarget_req", {31'b0, req_valid}, 32'd1);
        chk("retarget_addr", addr, 32'h200);
        // 6: reset mid-WAIT, late response ignored
        req_ready = 1; lat = 3;
        tick();
        rst = 0;
        #1;
        chk("t6_async_req", {31'b0, req_valid}, 32'd0);
        chk("t6_async_addr", addr, 32'h0);
        chk("t6_async_if_valid", {31'b0, if_valid}, 32'd0);
        tick();
        rst = 1; req_ready = 0;
        tick();
        chk("t6_late_rsp", {31'b0, rsp_valid}, 32'd1);
        chk("t6_req", {31'b0, req_valid}, 32'd1);
        chk("t6_addr", addr, 32'h0);
        tick();
        chk("t6_not_pushed", {31'b0, if_valid}, 32'd0);
        req_ready = 1; lat = 1; if_ready = 0;
        tick();
        tick();
        chk("t6_if_valid", {31'b0, if_valid}, 32'd1);
        chk("t6_if_pc", if_pc, 32'h0);
        chk("t6_if_instr", if_instr, fi(32'h0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
